// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types for the WISC fetch sequencer.
// Holds the sequencer state encoding and the PC increment helper.
package fetch_seq_ctrl_pkg;

  localparam int PC_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic [PC_W_DEF-1:0] pc_inc(
    input logic [PC_W_DEF-1:0] pc
  );
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// WISC fetch sequencer: owns the PC, the imem handshake,
// redirect/stall/halt sequencing and the ZR flag.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic            instr_vld,
  output logic [PC_W-1:0] pc_plus1,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_tgt,
  input  logic            hlt,
  input  logic            flag_we,
  input  logic            alu_zr,
  output logic            zr,
  output logic            halted
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] tgt;
  logic            drop_pend;
  logic            xfer;

  // Handshake and delivery are combinational so a ready memory
  // delivers in the request cycle; reset masks them at once.
  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state == ST_WAIT:  imem_req = 1'b1;
        state == ST_FETCH: imem_req = !stall;
        default:           imem_req = 1'b0;
      endcase
    end
    xfer      = imem_req & imem_rdy;
    instr_vld = xfer & !drop_pend;
    halted    = !rst & (state == ST_HALT);
    imem_addr = pc;
    pc_plus1  = pc + 1'b1;
    instr     = imem_data;
  end

  // Sequencer: state, PC, pending-redirect latch and ZR flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC[PC_W-1:0];
      tgt       <= '0;
      drop_pend <= 1'b0;
      zr        <= 1'b0;
    end else if (state != ST_HALT) begin
      if (xfer) begin
        state     <= ST_FETCH;
        drop_pend <= 1'b0;
        if (!drop_pend) begin
          if (flag_we) zr <= alu_zr;
          if (hlt) state <= ST_HALT;
          else if (br_taken) pc <= br_tgt;
          else pc <= pc + 1'b1;
        end else begin
          pc <= br_taken ? br_tgt : tgt;
        end
      end else if (state == ST_FETCH && stall) begin
        if (br_taken) pc <= br_tgt;
      end else begin
        // Request outstanding: addr stays put, redirect waits.
        state <= ST_WAIT;
        if (br_taken) begin
          drop_pend <= 1'b1;
          tgt       <= br_tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Randomised scoreboard bench for fetch_seq_ctrl.
// Model predicts each cycle's outputs; a monitor checks them.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_vld;
  logic [15:0] pc_plus1;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_tgt;
  logic        hlt;
  logic        flag_we;
  logic        alu_zr;
  logic        zr;
  logic        halted;

  fetch_seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_vld(instr_vld),
    .pc_plus1(pc_plus1), .stall(stall),
    .br_taken(br_taken), .br_tgt(br_tgt),
    .hlt(hlt), .flag_we(flag_we), .alu_zr(alu_zr),
    .zr(zr), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    int unsigned addr;
    bit          vld;
    int unsigned ins;
    int unsigned pp1;
    bit          zr;
    bit          halted;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model of the fetch stream
  int unsigned m_pc;
  bit          m_waiting;
  bit          m_halted;
  bit          m_redirect;
  int unsigned m_redir_to;
  bit          m_zr;

  task automatic chk(string nm, int unsigned act, int unsigned req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("imem_req", imem_req, e.req);
      chk("halted", halted, e.halted);
      chk("zr", zr, e.zr);
      chk("instr_vld", instr_vld, e.vld);
      if (e.req) chk("imem_addr", imem_addr, e.addr);
      if (e.req) chk("pc_plus1", pc_plus1, e.pp1);
      if (e.vld) chk("instr", instr, e.ins);
    end
  end

  task automatic cyc(bit r, bit rdy, bit st, bit br,
                     int unsigned tg, bit h, bit fwe, bit az);
    exp_t e;
    bit   take;
    rst = r; imem_rdy = rdy; stall = st; br_taken = br;
    br_tgt = tg[15:0]; hlt = h; flag_we = fwe; alu_zr = az;
    imem_data = 16'($urandom());
    e.req    = !r && !m_halted && (m_waiting || !st);
    take     = e.req && rdy;
    e.vld    = take && !m_redirect;
    e.addr   = m_pc;
    e.pp1    = (m_pc + 1) % 65536;
    e.ins    = imem_data;
    e.zr     = m_zr;
    e.halted = !r && m_halted;
    expq.push_back(e);
    if (r) begin
      m_pc = 0; m_waiting = 0; m_halted = 0;
      m_redirect = 0; m_zr = 0;
    end else if (m_halted) begin
    end else if (take) begin
      if (e.vld) begin
        if (fwe) m_zr = az;
        if (h) m_halted = 1;
        else m_pc = br ? tg : (m_pc + 1) % 65536;
      end else begin
        m_pc = br ? tg : m_redir_to;
      end
      m_waiting = 0; m_redirect = 0;
    end else if (!m_waiting && st) begin
      if (br) m_pc = tg;
    end else begin
      m_waiting = 1;
      if (br) begin m_redirect = 1; m_redir_to = tg; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(0, rdy, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int halt_cnt = 0;
    m_pc = 0; m_zr = 0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run(5, 1);
    run(3, 0);
    run(2, 1);
    cyc(0, 1, 0, 1, 16'h0010, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h0040, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    run(2, 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 16'h0100, 0, 0, 0);
    run(2, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 1);
    run(3, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 16'hFFFF, 0, 0, 0);
    run(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    run(2, 1);
    cyc(0, 1, 0, 1, 16'h0200, 1, 0, 0);
    run(4, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
      r = ($urandom_range(99) == 0) || (halt_cnt > 4);
      cyc(r,
          $urandom_range(99) < 65,
          $urandom_range(99) < 20,
          $urandom_range(99) < 12,
          $urandom_range(3) == 0 ? 16'hFFFE + $urandom_range(1)
                                 : $urandom_range(16'hFFFF),
          $urandom_range(99) < 3,
          $urandom_range(99) < 30,
          $urandom_range(1));
    end
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
